alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_unit.sv | 178 +++++++++++++++++
 tb/tb_alu_seq_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
//   Sequential ALU with a valid/ready handshake on both sides. An operation is
//   captured in IDLE, evaluated during one BUSY cycle, and the registered
//   result is presented in DONE until the consumer takes it.
//   Latency is 2 cycles from the accept edge to o_out_valid. One operation
//   completes at most every 3 cycles.
//
//   Optional feature macro: ALU_SEQ_FLAGS_EN
//     defined   : o_zero / o_carry / o_overflow are computed.
//     undefined : those three flags are tied to 0. o_err still works.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_in_valid           operation request (i_dato1, i_dato2, i_op_code)
//   o_in_ready           high only in IDLE
//   i_dato1, i_dato2     operand A, operand B (B is the shift amount)
//   i_op_code            ADD 100000, SUB 100010, AND 100100, OR 100101,
//                        XOR 100110, NOR 100111, SRL 000010, SRA 000011
//   o_out_valid          high only in DONE
//   i_out_ready          consumer takes the result
//   o_salida             registered result
//   o_zero, o_carry,
//   o_overflow, o_err    registered status flags
// -----------------------------------------------------------------------------
module alu_seq_unit #(
   parameter int NB_DATA = 8,
   parameter int NB_CODE = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [NB_DATA-1:0] i_dato1,
   input  logic [NB_DATA-1:0] i_dato2,
   input  logic [NB_CODE-1:0] i_op_code,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [NB_DATA-1:0] o_salida,
   output logic               o_zero,
   output logic               o_carry,
   output logic               o_overflow,
   output logic               o_err
);

   localparam logic [NB_CODE-1:0] OP_ADD = NB_CODE'(6'b100000);
   localparam logic [NB_CODE-1:0] OP_SUB = NB_CODE'(6'b100010);
   localparam logic [NB_CODE-1:0] OP_AND = NB_CODE'(6'b100100);
   localparam logic [NB_CODE-1:0] OP_OR  = NB_CODE'(6'b100101);
   localparam logic [NB_CODE-1:0] OP_XOR = NB_CODE'(6'b100110);
   localparam logic [NB_CODE-1:0] OP_NOR = NB_CODE'(6'b100111);
   localparam logic [NB_CODE-1:0] OP_SRL = NB_CODE'(6'b000010);
   localparam logic [NB_CODE-1:0] OP_SRA = NB_CODE'(6'b000011);

   // One bit wider than the operand so that a shift amount equal to NB_DATA
   // can be compared against it.
   localparam logic [NB_DATA:0] SH_LIM = (NB_DATA + 1)'(NB_DATA);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [NB_DATA-1:0]   a_q, b_q;
   logic [NB_CODE-1:0]   op_q;
   logic [NB_DATA-1:0]   res_q;
   logic                 zero_q, carry_q, ovf_q, err_q;

   logic                 accept;
   logic [NB_DATA-1:0]   res_c;
   logic                 err_c, zero_c, carry_c, ovf_c, sh_big;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               accept  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: state_d = DONE;
         DONE: begin
            o_out_valid = 1'b1;
            if (i_out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   assign sh_big = ({1'b0, b_q} >= SH_LIM);

   always_comb begin
      res_c = '0;
      err_c = 1'b0;
      case (op_q)
         OP_ADD: res_c = a_q + b_q;
         OP_SUB: res_c = a_q - b_q;
         OP_AND: res_c = a_q & b_q;
         OP_OR:  res_c = a_q | b_q;
         OP_XOR: res_c = a_q ^ b_q;
         OP_NOR: res_c = ~(a_q | b_q);
         OP_SRL: res_c = sh_big ? '0 : (a_q >> b_q);
         // Oversized arithmetic shifts saturate to the replicated sign bit.
         OP_SRA: res_c = sh_big ? {NB_DATA{a_q[NB_DATA-1]}}
                                : NB_DATA'($signed(a_q) >>> b_q);
         default: err_c = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_FLAGS_EN
   logic [NB_DATA:0] sum_w, dif_w;
   assign sum_w = {1'b0, a_q} + {1'b0, b_q};
   // The MSB of the widened difference is the unsigned borrow (a < b).
   assign dif_w = {1'b0, a_q} - {1'b0, b_q};

   always_comb begin
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      if (op_q == OP_ADD) begin
         carry_c = sum_w[NB_DATA];
         ovf_c   = (a_q[NB_DATA-1] == b_q[NB_DATA-1]) &&
                   (sum_w[NB_DATA-1] != a_q[NB_DATA-1]);
      end else if (op_q == OP_SUB) begin
         carry_c = dif_w[NB_DATA];
         ovf_c   = (a_q[NB_DATA-1] != b_q[NB_DATA-1]) &&
                   (dif_w[NB_DATA-1] != a_q[NB_DATA-1]);
      end
   end
   assign zero_c = (res_c == '0);
`else
   assign zero_c  = 1'b0;
   assign carry_c = 1'b0;
   assign ovf_c   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q  <= i_dato1;
            b_q  <= i_dato2;
            op_q <= i_op_code;
         end
         if (state_q == BUSY) begin
            res_q   <= res_c;
            zero_q  <= zero_c;
            carry_q <= carry_c;
            ovf_q   <= ovf_c;
            err_q   <= err_c;
         end
      end
   end

   assign o_salida   = res_q;
   assign o_zero     = zero_q;
   assign o_carry    = carry_q;
   assign o_overflow = ovf_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

   localparam int NB = 8;
`ifdef ALU_SEQ_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [NB-1:0] d1 = '0, d2 = '0, salida;
   logic [5:0]    op = '0;
   logic          zero, carry, ovf, err;

   int errors = 0;
   int checks = 0;

   alu_seq_unit #(.NB_DATA(NB), .NB_CODE(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_dato1(d1), .i_dato2(d2), .i_op_code(op),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_salida(salida), .o_zero(zero), .o_carry(carry),
      .o_overflow(ovf), .o_err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]    op;
      logic [NB-1:0] a, b, res;
      logic          z, c, v, e;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: integer arithmetic straight from the operation rules.
   function automatic vec_t model(input logic [5:0] o, input logic [NB-1:0] a,
                                  input logic [NB-1:0] b);
      vec_t r;
      int ua, ub, sa, sb, t;
      ua = int'(a); ub = int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      r.op = o; r.a = a; r.b = b;
      r.c = 0; r.v = 0; r.e = 0; t = 0;
      case (o)
         6'b100000: begin t = ua + ub; r.c = (t > 255); r.v = (sa + sb > 127) || (sa + sb < -128); end
         6'b100010: begin t = ua - ub; r.c = (ua < ub); r.v = (sa - sb > 127) || (sa - sb < -128); end
         6'b100100: t = ua & ub;
         6'b100101: t = ua | ub;
         6'b100110: t = ua ^ ub;
         6'b100111: t = 255 - (ua | ub);
         6'b000010: t = (ub >= NB) ? 0 : ua / (1 << ub);
         6'b000011: t = (ub >= NB) ? ((sa < 0) ? 255 : 0) : (sa >>> ub);
         default:   begin t = 0; r.e = 1; end
      endcase
      r.res = NB'(t & 255);
      r.z = (r.res == 0);
      if (!FL) begin r.z = 0; r.c = 0; r.v = 0; end
      return r;
   endfunction

   task automatic wait_ready(input string name);
      int n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin
         errors++; checks++;
         $display("FAIL %s: timeout waiting for o_in_ready, got 0 expected 1", name);
      end
   endtask

   task automatic check_out(input string name, input vec_t x);
      chk({name, " valid"}, int'(out_valid), 1);
      chk({name, " res"},   int'(salida), int'(x.res));
      chk({name, " zero"},  int'(zero), int'(x.z));
      chk({name, " carry"}, int'(carry), int'(x.c));
      chk({name, " ovf"},   int'(ovf), int'(x.v));
      chk({name, " err"},   int'(err), int'(x.e));
   endtask

   // Full transaction: accept, check BUSY, check DONE at +2, then drain.
   task automatic run_op(input string name, input vec_t x, input int stall);
      wait_ready(name);
      in_valid = 1; op = x.op; d1 = x.a; d2 = x.b;
      @(posedge clk); #1;
      in_valid = 0; d1 = $urandom; d2 = $urandom; op = $urandom;
      chk({name, " busy in_ready"}, int'(in_ready), 0);
      chk({name, " busy out_valid"}, int'(out_valid), 0);
      @(posedge clk); #1;
      check_out(name, x);
      for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
      if (stall > 0) check_out({name, " held"}, x);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk({name, " back idle"}, int'(in_ready), 1);
   endtask

   vec_t tbl[$];
   vec_t v;
   localparam logic [5:0] OPS[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                     6'b100110, 6'b100111, 6'b000010, 6'b000011};

   function automatic vec_t mk(input logic [5:0] o, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] r,
                               input bit z, input bit c, input bit ov, input bit e);
      vec_t t;
      t.op = o; t.a = a; t.b = b; t.res = r; t.e = e;
      t.z = FL & z; t.c = FL & c; t.v = FL & ov;
      return t;
   endfunction

   initial begin
      tbl.push_back(mk(6'b100000, 8'h06, 8'h04, 8'h0A, 0, 0, 0, 0));
      tbl.push_back(mk(6'b100010, 8'h06, 8'h04, 8'h02, 0, 0, 0, 0));
      tbl.push_back(mk(6'b100010, 8'h04, 8'h06, 8'hFE, 0, 1, 0, 0));
      tbl.push_back(mk(6'b100010, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0));
      tbl.push_back(mk(6'b100000, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 0));
      tbl.push_back(mk(6'b100000, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0));
      tbl.push_back(mk(6'b100010, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 0));
      tbl.push_back(mk(6'b000011, 8'h80, 8'h02, 8'hE0, 0, 0, 0, 0));
      tbl.push_back(mk(6'b000011, 8'h80, 8'h09, 8'hFF, 0, 0, 0, 0));
      tbl.push_back(mk(6'b000011, 8'h80, 8'h08, 8'hFF, 0, 0, 0, 0));
      tbl.push_back(mk(6'b000010, 8'h80, 8'h09, 8'h00, 1, 0, 0, 0));
      tbl.push_back(mk(6'b000010, 8'h80, 8'h07, 8'h01, 0, 0, 0, 0));
      tbl.push_back(mk(6'b100111, 8'h0F, 8'hF0, 8'h00, 1, 0, 0, 0));
      tbl.push_back(mk(6'b100100, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0));
      tbl.push_back(mk(6'b100101, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 0));
      tbl.push_back(mk(6'b100110, 8'hF0, 8'h3C, 8'hCC, 0, 0, 0, 0));
      tbl.push_back(mk(6'b111111, 8'h12, 8'h34, 8'h00, 1, 0, 0, 1));

      // Reset state
      #12;
      chk("reset in_ready", int'(in_ready), 1);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset salida", int'(salida), 0);
      chk("reset flags", int'({zero, carry, ovf, err}), 0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i], 0);

      // Stall in DONE for 5 cycles while new requests are offered.
      v = tbl[4];
      wait_ready("stall");
      in_valid = 1; op = v.op; d1 = v.a; d2 = v.b;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; op = 6'b100100; d1 = 8'hAA; d2 = 8'h55;
         @(posedge clk); #1;
         chk("stall in_ready", int'(in_ready), 0);
         check_out("stall", v);
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("stall drained valid", int'(out_valid), 0);
      @(posedge clk); #1;
      chk("stall no ghost op", int'(out_valid), 0);
      chk("stall idle", int'(in_ready), 1);

      // Reset during BUSY
      in_valid = 1; op = 6'b100000; d1 = 8'h11; d2 = 8'h22;
      @(posedge clk); #1;
      in_valid = 0;
      #2 rst_n = 0; #1;
      chk("rst busy salida", int'(salida), 0);
      chk("rst busy out_valid", int'(out_valid), 0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst busy no result", int'(out_valid), 0);
      end

      // Reset during DONE with a nonzero result on the outputs
      v = tbl[2];
      wait_ready("rst done");
      in_valid = 1; op = v.op; d1 = v.a; d2 = v.b;
      @(posedge clk); #1; in_valid = 0;
      @(posedge clk); #1;
      check_out("pre rst done", v);
      #2 rst_n = 0; #1;
      chk("rst done salida", int'(salida), 0);
      chk("rst done flags", int'({zero, carry, ovf, err}), 0);
      chk("rst done out_valid", int'(out_valid), 0);
      @(negedge clk); rst_n = 1;
      run_op("after rst", tbl[0], 0);

      // Randomised operations against the model
      for (int n = 0; n < 150; n++) begin
         logic [5:0] o;
         logic [7:0] a, b;
         o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 7)];
         a = 8'($urandom);
         b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         run_op($sformatf("rnd%0d", n), model(o, a, b), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
